fetch_unit: RTL and testbench

Instruction fetch stage for the pipelined MIPS core. Generates the PC, runs a request/ready handshake with instruction memory, and presents `ir`, an 8-bit `exception`, and the instruction's PC to the decode stage. The decoder consumes these as its `ir` / `exception_in` inputs. Handles stall replay, branch/jump redirects, misaligned-PC traps and fetch bus errors.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_skid_buffer.sv | 36 +++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the front end: exception codes handed to decode and
// the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam logic [7:0] TRAP_NONE        = 8'h00;
    localparam logic [7:0] TRAP_STALL       = 8'h01;
    localparam logic [7:0] TRAP_BAD_PC      = 8'h20;
    localparam logic [7:0] TRAP_FETCH_FAULT = 8'h21;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a fetch that completes while decode is stalled.
// Only the valid flag is reset; the payload is qualified by it.
module fetch_skid_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic        pop,
    input  logic [31:0] d_ir,
    input  logic [7:0]  d_exc,
    input  logic [31:0] d_pc,
    output logic        valid,
    output logic [31:0] q_ir,
    output logic [7:0]  q_exc,
    output logic [31:0] q_pc
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            q_ir  <= d_ir;
            q_exc <= d_exc;
            q_pc  <= d_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, imem request/ready handshake,
// stall replay through a skid buffer, redirects and fetch traps.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] ir,
    output logic [7:0]  exception,
    output logic [31:0] pc_out
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  drop_pc;
    logic         misaligned;
    logic         produce;
    logic         fault;
    logic [31:0]  new_ir;
    logic [7:0]   new_exc;
    logic         buf_valid;
    logic         buf_load;
    logic         buf_pop;
    logic [31:0]  buf_ir;
    logic [7:0]   buf_exc;
    logic [31:0]  buf_pc;

    assign misaligned = (pc[1:0] != 2'b00);
    assign imem_addr  = pc;

    // In DROP the old request must stay asserted until memory answers it.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            S_FETCH: imem_req = !buf_valid && !misaligned;
            S_DROP:  imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    // A slot is produced by a completing fetch or by a misaligned-PC trap.
    assign produce = (state == S_FETCH) && !buf_valid && (misaligned || imem_ready);
    assign fault   = misaligned || imem_err;

    always_comb begin
        new_ir  = imem_rdata;
        new_exc = TRAP_NONE;
        if (misaligned) begin
            new_ir  = '0;
            new_exc = TRAP_BAD_PC;
        end else if (imem_err) begin
            new_ir  = '0;
            new_exc = TRAP_FETCH_FAULT;
        end
    end

    assign buf_load = !redirect_valid && stall && produce;
    assign buf_pop  = !redirect_valid && !stall && buf_valid;

    fetch_skid_buffer u_skid (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .load  (buf_load),
        .pop   (buf_pop),
        .d_ir  (new_ir),
        .d_exc (new_exc),
        .d_pc  (pc),
        .valid (buf_valid),
        .q_ir  (buf_ir),
        .q_exc (buf_exc),
        .q_pc  (buf_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RESET;
            pc        <= RESET_PC;
            ir        <= '0;
            exception <= TRAP_STALL;
            pc_out    <= '0;
        end else begin
            if (!stall) begin
                if (redirect_valid || !(buf_valid || produce)) begin
                    ir        <= '0;
                    exception <= TRAP_STALL;
                    pc_out    <= '0;
                end else if (buf_valid) begin
                    ir        <= buf_ir;
                    exception <= buf_exc;
                    pc_out    <= buf_pc;
                end else begin
                    ir        <= new_ir;
                    exception <= new_exc;
                    pc_out    <= pc;
                end
            end

            // An unanswered request keeps its address; the target waits in drop_pc.
            if (redirect_valid) begin
                if (imem_req && !imem_ready) begin
                    state   <= S_DROP;
                    drop_pc <= redirect_pc;
                end else begin
                    state <= S_FETCH;
                    pc    <= redirect_pc;
                end
            end else begin
                case (state)
                    S_RESET: state <= S_FETCH;
                    S_FETCH: begin
                        if (produce) begin
                            if (fault) begin
                                state <= S_HALT;
                            end else begin
                                pc <= pc + 32'd4;
                            end
                        end
                    end
                    S_DROP: begin
                        if (imem_ready) begin
                            state <= S_FETCH;
                            pc    <= drop_pc;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset sequence, a directed vector table and a
// randomized run checked against a program-order reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] ir;
    logic [7:0]  exception;
    logic [31:0] pc_out;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0400)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .ir             (ir),
        .exception      (exception),
        .pc_out         (pc_out)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return a[6:2] == 5'h1F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        er;
        logic        xreq;
        logic [31:0] xaddr;
        logic [31:0] xir;
        logic [7:0]  xexc;
        logic [31:0] xpc;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic er, input logic xreq,
                                input logic [31:0] xaddr, input logic [31:0] xir,
                                input logic [7:0] xexc, input logic [31:0] xpc);
        vec_t v;
        v.st = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.er = er;
        v.xreq = xreq; v.xaddr = xaddr; v.xir = xir; v.xexc = xexc; v.xpc = xpc;
        return v;
    endfunction

    vec_t vt[24];

    // reference-model and random-run state
    logic [31:0] epc;
    logic        halted;
    int          wait_left;
    int          delivered;
    logic        p_req, p_rdy, p_st, p_rv;
    logic [31:0] p_addr, p_rpc, p_ir, p_pco;
    logic [7:0]  p_exc;
    logic [31:0] e_ir;
    logic [7:0]  e_exc;

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; imem_rdata = '0; imem_err = 1'b0;

        vt[0]  = mk(0, 0, 32'h0,   1, 0, 1, 32'h400, memw(32'h400), TRAP_NONE, 32'h400);
        vt[1]  = mk(0, 0, 32'h0,   1, 0, 1, 32'h404, memw(32'h404), TRAP_NONE, 32'h404);
        vt[2]  = mk(1, 0, 32'h0,   1, 0, 1, 32'h408, memw(32'h404), TRAP_NONE, 32'h404);
        vt[3]  = mk(1, 0, 32'h0,   0, 0, 0, 32'h40C, memw(32'h404), TRAP_NONE, 32'h404);
        vt[4]  = mk(0, 0, 32'h0,   0, 0, 0, 32'h40C, memw(32'h408), TRAP_NONE, 32'h408);
        vt[5]  = mk(0, 0, 32'h0,   1, 0, 1, 32'h40C, memw(32'h40C), TRAP_NONE, 32'h40C);
        vt[6]  = mk(0, 0, 32'h0,   0, 0, 1, 32'h410, 32'h0, TRAP_STALL, 32'h0);
        vt[7]  = mk(0, 1, 32'h800, 0, 0, 1, 32'h410, 32'h0, TRAP_STALL, 32'h0);
        vt[8]  = mk(0, 1, 32'h880, 0, 0, 1, 32'h410, 32'h0, TRAP_STALL, 32'h0);
        vt[9]  = mk(0, 0, 32'h0,   1, 0, 1, 32'h410, 32'h0, TRAP_STALL, 32'h0);
        vt[10] = mk(0, 0, 32'h0,   1, 0, 1, 32'h880, memw(32'h880), TRAP_NONE, 32'h880);
        vt[11] = mk(0, 1, 32'h802, 1, 0, 1, 32'h884, 32'h0, TRAP_STALL, 32'h0);
        vt[12] = mk(0, 0, 32'h0,   0, 0, 0, 32'h802, 32'h0, TRAP_BAD_PC, 32'h802);
        vt[13] = mk(0, 0, 32'h0,   0, 0, 0, 32'h802, 32'h0, TRAP_STALL, 32'h0);
        vt[14] = mk(0, 1, 32'h900, 0, 0, 0, 32'h802, 32'h0, TRAP_STALL, 32'h0);
        vt[15] = mk(0, 0, 32'h0,   1, 0, 1, 32'h900, memw(32'h900), TRAP_NONE, 32'h900);
        vt[16] = mk(0, 0, 32'h0,   1, 1, 1, 32'h904, 32'h0, TRAP_FETCH_FAULT, 32'h904);
        vt[17] = mk(1, 1, 32'hA00, 0, 0, 0, 32'h904, 32'h0, TRAP_FETCH_FAULT, 32'h904);
        vt[18] = mk(1, 0, 32'h0,   1, 0, 1, 32'hA00, 32'h0, TRAP_FETCH_FAULT, 32'h904);
        vt[19] = mk(0, 0, 32'h0,   0, 0, 0, 32'hA04, memw(32'hA00), TRAP_NONE, 32'hA00);
        vt[20] = mk(0, 0, 32'h0,   1, 0, 1, 32'hA04, memw(32'hA04), TRAP_NONE, 32'hA04);
        vt[21] = mk(0, 1, 32'hFFFF_FFFC, 1, 0, 1, 32'hA08, 32'h0, TRAP_STALL, 32'h0);
        vt[22] = mk(0, 0, 32'h0,   1, 0, 1, 32'hFFFF_FFFC, memw(32'hFFFF_FFFC), TRAP_NONE,
                    32'hFFFF_FFFC);
        vt[23] = mk(0, 0, 32'h0,   1, 0, 1, 32'h0, memw(32'h0), TRAP_NONE, 32'h0);

        // reset held for two edges, then released
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d_exc", i), 32'(exception), 32'(TRAP_STALL));
            chk($sformatf("rst%0d_ir", i), ir, 32'h0);
            chk($sformatf("rst%0d_req", i), 32'(imem_req), 32'h0);
            chk($sformatf("rst%0d_pc_out", i), pc_out, 32'h0);
        end
        rst = 1'b0;
        chk("release_req_low", 32'(imem_req), 32'h0);
        @(posedge clk); #1;
        chk("first_req", 32'(imem_req), 32'h1);
        chk("first_addr", imem_addr, 32'h400);
        chk("first_bubble", 32'(exception), 32'(TRAP_STALL));

        // directed vector table
        for (int i = 0; i < 24; i++) begin
            stall          = vt[i].st;
            redirect_valid = vt[i].rv;
            redirect_pc    = vt[i].rpc;
            imem_ready     = vt[i].rdy;
            imem_err       = vt[i].er;
            imem_rdata     = vt[i].rdy ? memw(vt[i].xaddr) : 32'hDEAD_BEEF;
            chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(vt[i].xreq));
            chk($sformatf("row%0d_addr", i), imem_addr, vt[i].xaddr);
            @(posedge clk); #1;
            chk($sformatf("row%0d_ir", i), ir, vt[i].xir);
            chk($sformatf("row%0d_exc", i), 32'(exception), 32'(vt[i].xexc));
            if (vt[i].xexc != TRAP_STALL)
                chk($sformatf("row%0d_pc_out", i), pc_out, vt[i].xpc);
        end

        // randomized run against the program-order model
        stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b0; imem_err = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        epc = 32'h400; halted = 1'b0; wait_left = 0; delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 15) == 0) redirect_pc = redirect_pc | 32'h2;
            imem_ready = 1'b0;
            if (imem_req) begin
                if (wait_left == 0) imem_ready = 1'b1;
                else wait_left--;
            end
            imem_rdata = memw(imem_addr);
            imem_err   = imem_ready && is_err(imem_addr);
            p_req = imem_req; p_addr = imem_addr; p_rdy = imem_ready;
            p_st = stall; p_rv = redirect_valid; p_rpc = redirect_pc;
            p_ir = ir; p_exc = exception; p_pco = pc_out;
            @(posedge clk); #1;
            if (p_req && p_rdy) wait_left = $urandom_range(0, 2);

            if (p_req && !p_rdy) begin
                chk("rnd_addr_stable", imem_addr, p_addr);
                chk("rnd_req_held", 32'(imem_req), 32'h1);
            end
            if (p_st) begin
                chk("rnd_hold_ir", ir, p_ir);
                chk("rnd_hold_exc", 32'(exception), 32'(p_exc));
                chk("rnd_hold_pc_out", pc_out, p_pco);
            end else if (p_rv) begin
                chk("rnd_redirect_bubble", 32'(exception), 32'(TRAP_STALL));
            end else if (exception == TRAP_STALL) begin
                chk("rnd_bubble_ir", ir, 32'h0);
            end else if (halted) begin
                chk("rnd_halt_bubble", 32'(exception), 32'(TRAP_STALL));
            end else begin
                if (epc[1:0] != 2'b00) begin
                    e_ir = 32'h0; e_exc = TRAP_BAD_PC; halted = 1'b1;
                end else if (is_err(epc)) begin
                    e_ir = 32'h0; e_exc = TRAP_FETCH_FAULT; halted = 1'b1;
                end else begin
                    e_ir = memw(epc); e_exc = TRAP_NONE;
                end
                chk("rnd_ir", ir, e_ir);
                chk("rnd_exc", 32'(exception), 32'(e_exc));
                chk("rnd_pc_out", pc_out, epc);
                if (!halted) epc = epc + 32'd4;
                delivered++;
            end
            if (p_rv) begin
                epc = p_rpc;
                halted = 1'b0;
            end
        end
        chk("rnd_progress", 32'(delivered >= 200), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
